load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core memory request at a time, checks alignment,
// issues a single Wishbone-master command and returns the extended load result.
package load_store_unit_pkg;
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } wb_command_t;
endpackage

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter logic [31:0] LOAD_ERR_DATA = 32'h0
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_store_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  output logic        done_out,
  output logic [31:0] load_data_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output wb_command_t cmd_out,
  output logic [31:0] addr_out,
  output logic [31:0] wdata_out,
  output logic [3:0]  wmask_out,
  input  logic        busy_in,
  input  logic        err_in,
  input  logic [31:0] rdata_in
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_store;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_addr_lo;
  logic [31:0] r_addr_out;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [31:0] r_load_data;
  logic        r_misaligned;
  logic        r_bus_err;

  logic        w_accept;
  logic        w_fault;
  logic [3:0]  w_mask;
  logic [31:0] w_lane_data;
  logic [31:0] w_shifted;
  logic [31:0] w_load_ext;
  logic        w_bus_done;

  assign w_accept   = req_valid_in && (r_state == IDLE);
  assign w_bus_done = (r_state == WAIT) && !busy_in;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    w_fault     = 1'b0;
    w_mask      = 4'b1111;
    w_lane_data = req_wdata_in;
    case (req_size_in)
      2'b00: begin
        w_mask      = 4'b0001 << req_addr_in[1:0];
        w_lane_data = {4{req_wdata_in[7:0]}};
      end
      2'b01: begin
        w_fault     = req_addr_in[0];
        w_mask      = 4'b0011 << {req_addr_in[1], 1'b0};
        w_lane_data = {2{req_wdata_in[15:0]}};
      end
      2'b10:   w_fault = |req_addr_in[1:0];
      default: w_fault = 1'b1;
    endcase
    // Loads always read the whole word; lane selection happens on return.
    if (!req_store_in) w_mask = 4'b1111;
  end

  assign w_shifted = rdata_in >> {r_addr_lo, 3'b000};

  always_comb begin
    w_load_ext = w_shifted;
    case (r_size)
      2'b00:   w_load_ext = {{24{w_shifted[7] & ~r_unsigned}}, w_shifted[7:0]};
      2'b01:   w_load_ext = {{16{w_shifted[15] & ~r_unsigned}}, w_shifted[15:0]};
      default: w_load_ext = rdata_in;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_fault ? DONE : ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (!busy_in) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_store      <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr_lo    <= 2'b00;
      r_addr_out   <= 32'h0;
      r_wdata      <= 32'h0;
      r_wmask      <= 4'h0;
      r_load_data  <= 32'h0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
    end else if (w_accept) begin
      r_store      <= req_store_in;
      r_size       <= req_size_in;
      r_unsigned   <= req_unsigned_in;
      r_addr_lo    <= req_addr_in[1:0];
      r_addr_out   <= {req_addr_in[31:2], 2'b00};
      r_wdata      <= w_lane_data;
      r_wmask      <= w_mask;
      r_misaligned <= w_fault;
      r_bus_err    <= 1'b0;
      r_load_data  <= (w_fault && !req_store_in) ? LOAD_ERR_DATA : 32'h0;
    end else if (w_bus_done) begin
      r_bus_err <= err_in;
      if (r_store)     r_load_data <= 32'h0;
      else if (err_in) r_load_data <= LOAD_ERR_DATA;
      else             r_load_data <= w_load_ext;
    end
  end

  assign req_ready_out  = (r_state == IDLE);
  assign done_out       = (r_state == DONE);
  assign cmd_out        = (r_state == ISSUE) ? (r_store ? STORE : LOAD) : NONE;
  assign addr_out       = r_addr_out;
  assign wdata_out      = r_wdata;
  assign wmask_out      = r_wmask;
  assign load_data_out  = r_load_data;
  assign misaligned_out = r_misaligned;
  assign bus_err_out    = r_bus_err;

endmodule
